i2c_register_sequencer: RTL and testbench



---
 rtl/i2c_register_sequencer.sv | 179 +++++++++++++++++
 tb/tb_i2c_register_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_register_sequencer.sv
// rtl/i2c_register_sequencer.sv - I2C single-register write/read sequencer over the byte engine (option macro: I2C_REPEATED_START_EN)
module i2c_register_sequencer #(
    parameter int Timeout_Cycles = 1_000_000
) (
    input  logic       ipClk,
    input  logic       Reset,
    input  logic       ipValid,
    output logic       opReady,
    input  logic       ipRead,
    input  logic [6:0] ipAddress,
    input  logic [7:0] ipRegister,
    input  logic [7:0] ipWrData,
    output logic [7:0] opRdData,
    output logic       opDone,
    output logic       opError,
    output logic       opTimeout,
    output logic [7:0] opTxData,
    output logic [3:0] opCommand,
    output logic       opGo,
    input  logic       ipBusy,
    input  logic [7:0] ipRxData,
    input  logic       ipError
);

    localparam int CW = (Timeout_Cycles > 1) ? $clog2(Timeout_Cycles) : 1;
    localparam logic [CW-1:0] TLAST = CW'(Timeout_Cycles - 1);

    // Command for the register-index byte of a read: plain byte before a
    // repeated start, or a byte ending in a full stop.
`ifdef I2C_REPEATED_START_EN
    localparam logic [3:0] REG_RD_CMD = 4'b0000;
`else
    localparam logic [3:0] REG_RD_CMD = 4'b0001;
`endif

    typedef enum logic [2:0] {sIdle, sLoad, sGo, sWait, sCheck, sDone} state_t;

    state_t        r_state;
    logic          r_read;
    logic [6:0]    r_addr;
    logic [7:0]    r_reg;
    logic [7:0]    r_wdata;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_go;
    logic          r_done;
    logic          r_err;
    logic          r_to;
    logic [7:0]    r_tx;
    logic [3:0]    r_cmd;
    logic [7:0]    r_rd;
    logic          r_drain;   // engine may still be busy from an aborted byte

    logic          w_ready;
    logic          w_accept;
    logic          w_last;
    logic          w_write_byte;
    logic [7:0]    w_tx;
    logic [3:0]    w_cmd;

    // Hold off new requests while the engine finishes a byte we abandoned.
    assign w_ready      = (r_state == sIdle) && !Reset && !(r_drain && ipBusy);
    assign w_accept     = ipValid && w_ready;
    assign w_last       = r_read ? (r_idx == 2'd3) : (r_idx == 2'd2);
    assign w_write_byte = !(r_read && (r_idx == 2'd3));

    // Byte/command table indexed by the byte position within the transaction.
    always_comb begin
        w_tx  = 8'h00;
        w_cmd = 4'b0000;
        case (r_idx)
            2'd0: begin w_tx = {r_addr, 1'b0}; w_cmd = 4'b1000; end
            2'd1: begin w_tx = r_reg; w_cmd = r_read ? REG_RD_CMD : 4'b0000; end
            2'd2: begin
                w_tx  = r_read ? {r_addr, 1'b1} : r_wdata;
                w_cmd = r_read ? 4'b1000 : 4'b0001;
            end
            default: begin w_tx = 8'h00; w_cmd = 4'b0101; end
        endcase
    end

    // Transaction FSM with registered engine handshake and status outputs.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            r_state <= sIdle;
            r_read  <= 1'b0;
            r_addr  <= 7'h00;
            r_reg   <= 8'h00;
            r_wdata <= 8'h00;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_go    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
            r_tx    <= 8'h00;
            r_cmd   <= 4'h0;
            r_rd    <= 8'h00;
            r_drain <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                sIdle: begin
                    if (!ipBusy) r_drain <= 1'b0;
                    if (w_accept) begin
                        r_read  <= ipRead;
                        r_addr  <= ipAddress;
                        r_reg   <= ipRegister;
                        r_wdata <= ipWrData;
                        r_idx   <= 2'd0;
                        r_err   <= 1'b0;
                        r_to    <= 1'b0;
                        r_state <= sLoad;
                    end
                end
                sLoad: begin
                    r_tx    <= w_tx;
                    r_cmd   <= w_cmd;
                    r_go    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= sGo;
                end
                sGo: begin
                    if (r_cnt == TLAST) begin
                        r_to    <= 1'b1;
                        r_go    <= 1'b0;
                        r_done  <= 1'b1;
                        r_drain <= 1'b1;
                        r_state <= sDone;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (ipBusy) begin
                            r_go    <= 1'b0;
                            r_state <= sWait;
                        end
                    end
                end
                sWait: begin
                    if (!ipBusy) begin
                        r_state <= sCheck;
                    end else if (r_cnt == TLAST) begin
                        r_to    <= 1'b1;
                        r_done  <= 1'b1;
                        r_drain <= 1'b1;
                        r_state <= sDone;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                sCheck: begin
                    if (ipError && w_write_byte) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= sDone;
                    end else if (w_last) begin
                        if (r_read) r_rd <= ipRxData;
                        r_done  <= 1'b1;
                        r_state <= sDone;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= sLoad;
                    end
                end
                sDone:   r_state <= sIdle;
                default: r_state <= sIdle;
            endcase
        end
    end

    assign opReady   = w_ready;
    assign opRdData  = r_rd;
    assign opDone    = r_done;
    assign opError   = r_err;
    assign opTimeout = r_to;
    assign opTxData  = r_tx;
    assign opCommand = r_cmd;
    assign opGo      = r_go;

endmodule

// File: tb/tb_i2c_register_sequencer.sv
// tb/tb_i2c_register_sequencer.sv - directed table-driven bench for i2c_register_sequencer with a behavioural byte engine
module tb_i2c_register_sequencer;

`ifdef I2C_REPEATED_START_EN
    localparam logic [3:0] C1 = 4'h0;
`else
    localparam logic [3:0] C1 = 4'h1;
`endif

    logic       ipClk = 1'b0;
    logic       Reset = 1'b1;
    logic       ipValid = 1'b0;
    logic       ipRead = 1'b0;
    logic [6:0] ipAddress = 7'h00;
    logic [7:0] ipRegister = 8'h00;
    logic [7:0] ipWrData = 8'h00;
    logic       ipBusy = 1'b0;
    logic [7:0] ipRxData = 8'h00;
    logic       ipError = 1'b0;
    logic       opReady, opDone, opError, opTimeout, opGo;
    logic [7:0] opRdData, opTxData;
    logic [3:0] opCommand;

    always #5 ipClk = ~ipClk;

    i2c_register_sequencer #(.Timeout_Cycles(100)) dut (
        .ipClk(ipClk), .Reset(Reset), .ipValid(ipValid), .opReady(opReady),
        .ipRead(ipRead), .ipAddress(ipAddress), .ipRegister(ipRegister),
        .ipWrData(ipWrData), .opRdData(opRdData), .opDone(opDone),
        .opError(opError), .opTimeout(opTimeout), .opTxData(opTxData),
        .opCommand(opCommand), .opGo(opGo), .ipBusy(ipBusy),
        .ipRxData(ipRxData), .ipError(ipError)
    );

    // Byte engine model: starts on Go, stays busy eng_len cycles (or until
    // released when hanging), reports ack error on the byte numbered nack_abs.
    int          eng_len = 4;
    bit          eng_hang = 1'b0;
    int          nack_abs = -1;
    logic [7:0]  rx_byte = 8'h00;
    logic [11:0] eng_log [16];
    int          eng_n = 0;
    int          eng_left = 0;
    int          go_rises = 0;
    int          done_cnt = 0;
    logic        go_prev = 1'b0;

    always @(negedge ipClk) begin
        if (opGo && !go_prev) go_rises++;
        go_prev = opGo;
        if (opDone) done_cnt++;
        if (ipBusy) begin
            if (!eng_hang) begin
                if (eng_left <= 1) begin
                    ipBusy   = 1'b0;
                    ipError  = ((eng_n - 1) == nack_abs);
                    ipRxData = opCommand[2] ? rx_byte : 8'hEE;
                end else begin
                    eng_left--;
                end
            end
        end else if (opGo) begin
            eng_log[eng_n % 16] = {opTxData, opCommand};
            eng_n++;
            ipBusy   = 1'b1;
            ipError  = 1'b0;
            eng_left = eng_len;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge ipClk);
        #1;
    endtask

    task automatic start_req(input logic rd, input logic [6:0] a, input logic [7:0] r, input logic [7:0] w);
        bit rdy;
        rdy = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (opReady) begin rdy = 1'b1; break; end
            step();
        end
        chk("ready_wait", {31'd0, rdy}, 32'd1);
        ipRead = rd; ipAddress = a; ipRegister = r; ipWrData = w;
        ipValid = 1'b1;
        step();
        ipValid = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output logic [7:0] rd, output logic er, output logic to);
        ok = 1'b0; rd = 8'h00; er = 1'b0; to = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (opDone) begin
                ok = 1'b1; rd = opRdData; er = opError; to = opTimeout;
                break;
            end
        end
    endtask

    typedef struct {
        logic             rd;
        logic [6:0]       addr;
        logic [7:0]       rg;
        logic [7:0]       wd;
        logic [7:0]       rx;
        int               nack;
        int               n;
        logic [3:0][11:0] b;
        logic [7:0]       exp_rd;
        logic             exp_err;
    } vec_t;

    function automatic vec_t mk(logic rd, logic [6:0] a, logic [7:0] r, logic [7:0] w, logic [7:0] rx,
                                int nk, int n, logic [11:0] b0, logic [11:0] b1, logic [11:0] b2,
                                logic [11:0] b3, logic [7:0] erd, logic eerr);
        vec_t v;
        v.rd = rd; v.addr = a; v.rg = r; v.wd = w; v.rx = rx; v.nack = nk; v.n = n;
        v.b = {b3, b2, b1, b0}; v.exp_rd = erd; v.exp_err = eerr;
        return v;
    endfunction

    vec_t vt [7];

    initial begin
        bit         ok;
        logic [7:0] rd;
        logic       er, to;
        int         n0, g0, d0, cyc, go_cyc, bad;

        vt[0] = mk(0, 7'h50, 8'h1A, 8'hC3, 8'h00, -1, 3, 12'hA08, 12'h1A0, 12'hC31, 12'h000, 8'h00, 0);
        vt[1] = mk(1, 7'h50, 8'h07, 8'h00, 8'h5E, -1, 4, 12'hA08, {8'h07, C1}, 12'hA18, 12'h005, 8'h5E, 0);
        vt[2] = mk(0, 7'h50, 8'h1A, 8'hC3, 8'h00, 0, 1, 12'hA08, 12'h000, 12'h000, 12'h000, 8'h5E, 1);
        vt[3] = mk(0, 7'h2A, 8'hFF, 8'h00, 8'h00, -1, 3, 12'h548, 12'hFF0, 12'h001, 12'h000, 8'h5E, 0);
        vt[4] = mk(1, 7'h7F, 8'h80, 8'h00, 8'hA5, -1, 4, 12'hFE8, {8'h80, C1}, 12'hFF8, 12'h005, 8'hA5, 0);
        vt[5] = mk(1, 7'h11, 8'h22, 8'h00, 8'h99, 1, 2, 12'h228, {8'h22, C1}, 12'h000, 12'h000, 8'hA5, 1);
        vt[6] = mk(1, 7'h11, 8'h22, 8'h00, 8'h3C, 3, 4, 12'h228, {8'h22, C1}, 12'h238, 12'h005, 8'h3C, 0);

        // Reset values
        repeat (3) step();
        chk("rst_outputs", {opReady, opGo, opDone, opError, opTimeout, opTxData, opCommand, opRdData}, 32'd0);
        Reset = 1'b0;
        step();
        chk("rst_ready_after", {31'd0, opReady}, 32'd1);

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            n0 = eng_n; g0 = go_rises; d0 = done_cnt;
            nack_abs = (vt[i].nack < 0) ? -1 : n0 + vt[i].nack;
            rx_byte  = vt[i].rx;
            start_req(vt[i].rd, vt[i].addr, vt[i].rg, vt[i].wd);
            wait_done(ok, rd, er, to);
            chk($sformatf("v%0d_done", i), {31'd0, ok}, 32'd1);
            repeat (2) step();
            chk($sformatf("v%0d_nbytes", i), eng_n - n0, vt[i].n);
            chk($sformatf("v%0d_gopulses", i), go_rises - g0, vt[i].n);
            chk($sformatf("v%0d_donepulses", i), done_cnt - d0, 1);
            for (int k = 0; k < vt[i].n; k++)
                chk($sformatf("v%0d_byte%0d", i, k), {20'd0, eng_log[(n0 + k) % 16]}, {20'd0, vt[i].b[k]});
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            chk($sformatf("v%0d_rddata", i), {24'd0, rd}, {24'd0, vt[i].exp_rd});
            chk($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
        end
        nack_abs = -1;

        // Accept to first Go: two cycles
        start_req(0, 7'h33, 8'h44, 8'h55);
        chk("lat_cycle1_go", {31'd0, opGo}, 32'd0);
        step();
        chk("lat_cycle2_go", {31'd0, opGo}, 32'd1);
        wait_done(ok, rd, er, to);
        chk("lat_done", {31'd0, ok}, 32'd1);

        // Held ipValid is re-accepted when opReady returns
        n0 = eng_n;
        while (!opReady) step();
        ipRead = 1'b0; ipAddress = 7'h50; ipRegister = 8'h01; ipWrData = 8'h02; ipValid = 1'b1;
        step();
        wait_done(ok, rd, er, to);
        chk("held_done1", {31'd0, ok}, 32'd1);
        step();
        chk("held_ready_back", {31'd0, opReady}, 32'd1);
        step();
        chk("held_reaccepted", {31'd0, opReady}, 32'd0);
        ipValid = 1'b0;
        wait_done(ok, rd, er, to);
        chk("held_done2", {31'd0, ok}, 32'd1);
        chk("held_nbytes", eng_n - n0, 6);

        // Engine hangs busy: timeout after ~100 cycles, drain before ready
        eng_hang = 1'b1;
        g0 = go_rises;
        start_req(0, 7'h50, 8'h1A, 8'hC3);
        cyc = 0; go_cyc = -1; ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            cyc++;
            if (opGo && go_cyc < 0) go_cyc = cyc;
            if (opDone) begin ok = 1'b1; break; end
        end
        chk("to_done", {31'd0, ok}, 32'd1);
        chk("to_latency", {31'd0, ((cyc - go_cyc) >= 99) && ((cyc - go_cyc) <= 101)}, 32'd1);
        chk("to_flags", {opTimeout, opError, opGo}, 3'b100);
        chk("to_gopulses", go_rises - g0, 1);
        bad = 0;
        repeat (20) begin
            step();
            if (opReady) bad++;
        end
        chk("to_ready_held_low", bad, 0);
        eng_hang = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (!ipBusy) begin ok = 1'b1; break; end
        end
        chk("to_busy_release", {31'd0, ok}, 32'd1);
        chk("to_ready_after_release", {31'd0, opReady}, 32'd1);
        start_req(0, 7'h50, 8'h1A, 8'hC3);
        wait_done(ok, rd, er, to);
        chk("to_next_write", {29'd0, ok, er, to}, 32'b100);

        // Reset during byte 2 of a read
        eng_len = 20;
        rx_byte = 8'h5E;
        n0 = eng_n;
        start_req(1, 7'h50, 8'h07, 8'h00);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if ((eng_n - n0) == 3 && ipBusy) begin ok = 1'b1; break; end
            step();
        end
        chk("mid_reach_byte2", {31'd0, ok}, 32'd1);
        Reset = 1'b1;
        step();
        chk("mid_rst_outputs", {opReady, opGo, opDone, opError, opTimeout, opTxData, opCommand, opRdData}, 32'd0);
        Reset = 1'b0;
        chk("mid_ready_while_busy", {31'd0, opReady}, 32'd0);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (!ipBusy) begin ok = 1'b1; break; end
        end
        chk("mid_busy_release", {31'd0, ok}, 32'd1);
        chk("mid_ready_after", {31'd0, opReady}, 32'd1);
        eng_len = 4;
        n0 = eng_n;
        start_req(0, 7'h50, 8'h1A, 8'hC3);
        wait_done(ok, rd, er, to);
        chk("mid_next_write", {29'd0, ok, er, to}, 32'b100);
        chk("mid_next_nbytes", eng_n - n0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
